// File: rtl/dp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dp_sched_pkg
// Brief   : Shared types, constants and tap-extraction helper for the
//           dot-product scheduler family.
// Revision: 1.0 - initial release
// ============================================================================
package dp_sched_pkg;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int MAX_W           = 64;
    localparam int MAX_REQ         = 16;
    localparam int TAPV_W          = MAX_REQ * 4 * MAX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } dp_state_e;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] EMIT  = ST_EMIT;

    // Tap k of requester i from a zero-extended packed activation vector of tap width w.
    function automatic logic [MAX_W-1:0] get_tap(
        input logic [TAPV_W-1:0] vec,
        input int                i,
        input int                k,
        input int                w
    );
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        return MAX_W'(vec >> ((i * 4 + k) * w)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; searches upward from last_id+1.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    output logic           found,
    output logic [IDW-1:0] win_id
);

    logic [IDW:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        w_idx  = '0;
        for (int off = N; off >= 1; off--) begin
            w_idx = {1'b0, last_id} + (IDW + 1)'(off);
            if (w_idx >= (IDW + 1)'(N)) begin
                w_idx = w_idx - (IDW + 1)'(N);
            end
            if (req[w_idx[IDW-1:0]]) begin
                found  = 1'b1;
                win_id = w_idx[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dot_product_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : dot_product_scheduler
// Brief   : Round-robin sharing of one 4-tap dot-product engine with watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module dot_product_scheduler
    import dp_sched_pkg::*;
#(
    parameter int W       = 16,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*4*W-1:0]   req_a,
    output logic [N_REQ-1:0]       gnt,
    output logic                   eng_start,
    output logic signed [W-1:0]    eng_a0,
    output logic signed [W-1:0]    eng_a1,
    output logic signed [W-1:0]    eng_a2,
    output logic signed [W-1:0]    eng_a3,
    output logic [IDW-1:0]         eng_bank,
    input  logic signed [2*W-1:0]  eng_out,
    input  logic                   eng_out_v,
    output logic signed [2*W-1:0]  res,
    output logic [IDW-1:0]         res_id,
    output logic                   res_v,
    output logic                   res_err,
    output logic                   busy
);

    localparam logic [7:0] c_tmo_limit = 8'(TIMEOUT);

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_last_id;
    logic [7:0]       r_tmo_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_win_id;
    logic [N_REQ-1:0] w_onehot;
    logic [W-1:0]     w_taps [N_REQ][4];

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req     (req),
        .last_id (r_last_id),
        .found   (w_found),
        .win_id  (w_win_id)
    );

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_req
            for (genvar k = 0; k < 4; k++) begin : g_tap
                assign w_taps[i][k] = W'(get_tap(TAPV_W'(req_a), i, k, W));
            end
        end
    endgenerate

    assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last_id <= IDW'(N_REQ - 1);
            r_tmo_cnt <= '0;
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_a0    <= '0;
            eng_a1    <= '0;
            eng_a2    <= '0;
            eng_a3    <= '0;
            eng_bank  <= '0;
            res       <= '0;
            res_id    <= '0;
            res_v     <= 1'b0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            eng_start <= 1'b0;
            res_v     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state   <= ISSUE;
                        r_last_id <= w_win_id;
                        eng_bank  <= w_win_id;
                        res_id    <= w_win_id;
                        eng_a0    <= w_taps[w_win_id][0];
                        eng_a1    <= w_taps[w_win_id][1];
                        eng_a2    <= w_taps[w_win_id][2];
                        eng_a3    <= w_taps[w_win_id][3];
                        gnt       <= w_onehot;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state   <= WAIT;
                    r_tmo_cnt <= 8'd1;
                end
                WAIT: begin
                    // A valid result in the watchdog's final cycle still counts as success.
                    if (eng_out_v) begin
                        r_state <= EMIT;
                        res     <= eng_out;
                        res_err <= 1'b0;
                        res_v   <= 1'b1;
                    end else if (r_tmo_cnt == c_tmo_limit) begin
                        r_state <= EMIT;
                        res     <= '0;
                        res_err <= 1'b1;
                        res_v   <= 1'b1;
                    end else if (r_tmo_cnt != 8'hFF) begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                EMIT: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_dot_product_scheduler
// Brief   : Directed scoreboard bench with a latency-programmable engine model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dot_product_scheduler;

    localparam int W       = 16;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 15;
    localparam int IDW     = 2;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req   = '0;
    logic [N_REQ*4*W-1:0] req_a = '0;
    logic [N_REQ-1:0]     gnt;
    logic                 eng_start;
    logic [W-1:0]         eng_a0, eng_a1, eng_a2, eng_a3;
    logic [IDW-1:0]       eng_bank;
    logic [2*W-1:0]       eng_out   = '0;
    logic                 eng_out_v = 1'b0;
    logic [2*W-1:0]       res;
    logic [IDW-1:0]       res_id;
    logic                 res_v, res_err, busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          eng_lat = 0;
    logic [31:0] eng_val = '0;
    logic [31:0] cur_val = '0;
    int          cd      = 0;
    bit          stray   = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    dot_product_scheduler #(
        .W       (W),
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .gnt       (gnt),
        .eng_start (eng_start),
        .eng_a0    (eng_a0),
        .eng_a1    (eng_a1),
        .eng_a2    (eng_a2),
        .eng_a3    (eng_a3),
        .eng_bank  (eng_bank),
        .eng_out   (eng_out),
        .eng_out_v (eng_out_v),
        .res       (res),
        .res_id    (res_id),
        .res_v     (res_v),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: answers eng_lat cycles after eng_start (0 = never answers).
    always @(posedge clk) begin
        #2;
        eng_out_v = 1'b0;
        if (!rst_n) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_out_v = 1'b1;
                    eng_out   = cur_val;
                end
            end
            if (stray) begin
                eng_out_v = 1'b1;
                eng_out   = 32'hDEAD_BEEF;
                stray     = 1'b0;
            end
            if (eng_start && eng_lat > 0) begin
                cd      = eng_lat;
                cur_val = eng_val;
            end
        end
    end

    function automatic logic [15:0] tap(input int i, input int k);
        if (i == 3) return 16'(-(k + 1));
        return 16'(i * 16 + k + 1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_grant(input logic [N_REQ-1:0] r, input int exp_id, input int lat,
                            input logic [31:0] val, input bit drop, output int t0);
        int               n;
        logic [N_REQ-1:0] onehot;
        t0      = cyc;
        req     = r;
        eng_lat = lat;
        eng_val = val;
        n       = 0;
        step();
        while (gnt === '0 && n < 20) begin
            step();
            n++;
        end
        onehot         = '0;
        onehot[exp_id] = 1'b1;
        chk("gnt", gnt, onehot);
        chk("gnt_cycle", cyc, t0 + 1);
        chk("eng_start", eng_start, 1'b1);
        chk("eng_bank", eng_bank, exp_id);
        chk("eng_taps", {eng_a0, eng_a1, eng_a2, eng_a3},
            {tap(exp_id, 0), tap(exp_id, 1), tap(exp_id, 2), tap(exp_id, 3)});
        chk("busy_issue", busy, 1'b1);
        if (drop) req = '0;
    endtask

    task automatic wait_result();
        int   n;
        exp_t e;
        n = 0;
        while (res_v !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (res_v !== 1'b1) begin
            chk("res_v_timeout", res_v, 1'b1);
        end else if (sb.size() == 0) begin
            chk("sb_depth", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("res", {res}, e.res);
            chk("res_id", res_id, e.id);
            chk("res_err", res_err, e.err);
            chk("res_cycle", cyc, e.cyc);
        end
        step();
        chk("res_v_pulse", res_v, 1'b0);
    endtask

    task automatic txn(input logic [N_REQ-1:0] r, input int exp_id, input int lat,
                       input logic [31:0] val, input bit drop);
        int  t0;
        bit  ok;
        ok = (lat > 0 && lat <= TIMEOUT);
        sb.push_back('{exp_id, ok ? val : 32'h0, ~ok, cyc + (ok ? lat + 2 : TIMEOUT + 2)});
        do_grant(r, exp_id, lat, val, drop, t0);
        wait_result();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        bit seen;
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 4; k++)
                req_a[(i * 4 + k) * W +: W] = tap(i, k);

        repeat (3) step();
        chk("reset_outputs", {gnt, eng_start, eng_a0, eng_a1, eng_a2, eng_a3, eng_bank,
                              res, res_id, res_v, res_err, busy}, '0);
        rst_n = 1'b1;
        step();

        // fairness with all four requesting
        for (int j = 0; j < 8; j++)
            txn(4'b1111, j % 4, 5, 32'h0000_1000 + j, j == 7);

        // single request, L=5
        txn(4'b0001, 0, 5, 32'h0000_1234, 1'b1);

        // stray engine pulse while idle
        stray = 1'b1;
        seen  = 1'b0;
        repeat (4) begin
            step();
            if (res_v) seen = 1'b1;
        end
        chk("stray_res_v", seen, 1'b0);
        chk("stray_busy", busy, 1'b0);
        chk("stray_res", {res}, 32'h0000_1234);

        // wrap and skip
        txn(4'b0100, 2, 5, 32'h0000_2222, 1'b1);
        txn(4'b0011, 0, 5, 32'h0000_3333, 1'b0);
        txn(4'b0011, 1, 5, 32'h0000_4444, 1'b1);

        // watchdog, then normal service
        txn(4'b0001, 0, 0, 32'h0000_9999, 1'b1);
        txn(4'b1000, 3, 5, 32'h0000_5555, 1'b1);

        // result on the exact timeout cycle, negative value
        txn(4'b0010, 1, TIMEOUT, 32'hFFFF_FF00, 1'b1);

        // reset in the third WAIT cycle
        do_grant(4'b0001, 0, 0, 32'h0, 1'b1, t0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_outputs", {gnt, eng_start, eng_a0, eng_a1, eng_a2, eng_a3, eng_bank,
                                      res, res_id, res_v, res_err, busy}, '0);
        seen = 1'b0;
        repeat (4) begin
            step();
            if (res_v) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            step();
            if (res_v) seen = 1'b1;
        end
        chk("midwait_no_res_v", seen, 1'b0);
        chk("midwait_busy", busy, 1'b0);
        txn(4'b0100, 2, 5, 32'h0777_0001, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
